// File: rtl/gaplus_input_pkg.sv
// Shared constants for the Gaplus input conditioning stage: PS/2 scan codes,
// joystick bit positions and the coin shaper state encoding.
package gaplus_input_pkg;

    localparam logic [7:0] KC_UP    = 8'h75;
    localparam logic [7:0] KC_DOWN  = 8'h72;
    localparam logic [7:0] KC_LEFT  = 8'h6B;
    localparam logic [7:0] KC_RIGHT = 8'h74;
    localparam logic [7:0] KC_SPACE = 8'h29;
    localparam logic [7:0] KC_LCTRL = 8'h14;
    localparam logic [7:0] KC_F1    = 8'h05;
    localparam logic [7:0] KC_F2    = 8'h06;
    localparam logic [7:0] KC_1     = 8'h16;
    localparam logic [7:0] KC_2     = 8'h1E;
    localparam logic [7:0] KC_5     = 8'h2E;
    localparam logic [7:0] KC_6     = 8'h36;
    localparam logic [7:0] KC_R     = 8'h2D;
    localparam logic [7:0] KC_F     = 8'h2B;
    localparam logic [7:0] KC_D     = 8'h23;
    localparam logic [7:0] KC_G     = 8'h34;
    localparam logic [7:0] KC_A     = 8'h1C;
    localparam logic [7:0] KC_S     = 8'h1B;

    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_D      = 2;
    localparam int JOY_U      = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;
    localparam int JOY_COIN   = 7;

    typedef enum logic [1:0] {IDLE, PULSE, LOCK, WAIT_REL} coin_state_t;

    typedef struct packed {
        logic up1, down1, left1, right1, trig1;
        logic up2, down2, left2, right2, trig2;
        logic f1, f2, start1, start2, coin1, coin2;
    } keys_t;

endpackage

// File: rtl/gaplus_coin_shaper.sv
// Turns a raw coin request into a pulse lasting PULSE_FRAMES vblank edges,
// followed by LOCK_FRAMES edges of lockout; a held request credits once.
module gaplus_coin_shaper
    import gaplus_input_pkg::*;
#(
    parameter int PULSE_FRAMES = 4,
    parameter int LOCK_FRAMES  = 8,
    parameter int CNT_W        = 4
) (
    input  logic MCLK,
    input  logic RESET,
    input  logic raw,
    input  logic vb_rise,
    output logic out
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_FRAMES);
    localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    coin_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             raw_q, armed_q, raw_edge;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            raw_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            raw_q   <= raw;
            armed_q <= 1'b1;
        end
    end

    // armed_q blocks the first post-reset cycle so a coin held through reset is not an edge
    assign raw_edge = raw & ~raw_q & armed_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out       = 1'b0;
        case (state)
            IDLE: begin
                if (raw_edge) begin
                    state_nxt = PULSE;
                    cnt_nxt   = PULSE_LOAD;
                end
            end
            PULSE: begin
                out = 1'b1;
                if (vb_rise) begin
                    if (cnt == CNT_ONE) begin
                        state_nxt = LOCK;
                        cnt_nxt   = LOCK_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
            end
            LOCK: begin
                if (vb_rise) begin
                    if (cnt == CNT_ONE) begin
                        state_nxt = raw ? WAIT_REL : IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
            end
            WAIT_REL: begin
                if (!raw) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/gaplus_input_cond.sv
// Input conditioning for the Gaplus core: PS/2 key decode, joystick merge,
// upright/cocktail player mirroring and frame-timed coin pulses.
module gaplus_input_cond
    import gaplus_input_pkg::*;
#(
    parameter int PULSE_FRAMES = 4,
    parameter int LOCK_FRAMES  = 8,
    parameter int CNT_W        = 4
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic [10:0] PS2_KEY,
    input  logic [15:0] JOY1,
    input  logic [15:0] JOY2,
    input  logic        VBLK,
    input  logic        COCKTAIL,
    output logic [4:0]  INP0,
    output logic [4:0]  INP1,
    output logic [2:0]  INP2
);

    keys_t      keys;
    logic       tog_q, vblk_q, vb_rise;
    logic       pressed, ext;
    logic [7:0] code;
    logic [4:0] p1_lvl, p2_lvl;
    logic       start1, start2, raw_coin1, raw_coin2, coin1_out, coin2_out;
    logic       unused_joy_hi;

    assign pressed = PS2_KEY[9];
    assign ext     = PS2_KEY[8];
    assign code    = PS2_KEY[7:0];

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            tog_q <= 1'b0;
            keys  <= '0;
        end else begin
            tog_q <= PS2_KEY[10];
            if (PS2_KEY[10] != tog_q) begin
                // arrow codes match with or without the extended prefix
                case (code)
                    KC_UP:    keys.up1    <= pressed;
                    KC_DOWN:  keys.down1  <= pressed;
                    KC_LEFT:  keys.left1  <= pressed;
                    KC_RIGHT: keys.right1 <= pressed;
                    default: begin
                        if (!ext) begin
                            case (code)
                                KC_SPACE, KC_LCTRL: keys.trig1  <= pressed;
                                KC_F1:              keys.f1     <= pressed;
                                KC_F2:              keys.f2     <= pressed;
                                KC_1:               keys.start1 <= pressed;
                                KC_2:               keys.start2 <= pressed;
                                KC_5:               keys.coin1  <= pressed;
                                KC_6:               keys.coin2  <= pressed;
                                KC_R:               keys.up2    <= pressed;
                                KC_F:               keys.down2  <= pressed;
                                KC_D:               keys.left2  <= pressed;
                                KC_G:               keys.right2 <= pressed;
                                KC_A, KC_S:         keys.trig2  <= pressed;
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign p2_lvl = {keys.trig2  | JOY2[JOY_FIRE],
                     keys.left2  | JOY2[JOY_L],
                     keys.down2  | JOY2[JOY_D],
                     keys.right2 | JOY2[JOY_R],
                     keys.up2    | JOY2[JOY_U]};

    assign p1_lvl = {keys.trig1  | JOY1[JOY_FIRE],
                     keys.left1  | JOY1[JOY_L],
                     keys.down1  | JOY1[JOY_D],
                     keys.right1 | JOY1[JOY_R],
                     keys.up1    | JOY1[JOY_U]} | (COCKTAIL ? 5'b0 : p2_lvl);

    assign start1    = keys.f1 | keys.start1 | JOY1[JOY_START1] | JOY2[JOY_START1];
    assign start2    = keys.f2 | keys.start2 | JOY1[JOY_START2] | JOY2[JOY_START2];
    assign raw_coin1 = keys.f1 | keys.coin1 | JOY1[JOY_COIN];
    assign raw_coin2 = keys.f2 | keys.coin2 | JOY2[JOY_COIN];

    assign unused_joy_hi = ^{JOY1[15:8], JOY2[15:8]};
    assign vb_rise       = VBLK & ~vblk_q;

    gaplus_coin_shaper #(
        .PULSE_FRAMES(PULSE_FRAMES), .LOCK_FRAMES(LOCK_FRAMES), .CNT_W(CNT_W)
    ) u_coin1 (
        .MCLK(MCLK), .RESET(RESET), .raw(raw_coin1), .vb_rise(vb_rise), .out(coin1_out)
    );

    gaplus_coin_shaper #(
        .PULSE_FRAMES(PULSE_FRAMES), .LOCK_FRAMES(LOCK_FRAMES), .CNT_W(CNT_W)
    ) u_coin2 (
        .MCLK(MCLK), .RESET(RESET), .raw(raw_coin2), .vb_rise(vb_rise), .out(coin2_out)
    );

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            vblk_q <= 1'b0;
            INP0   <= '0;
            INP1   <= '0;
            INP2   <= '0;
        end else begin
            vblk_q <= VBLK;
            INP0   <= p1_lvl;
            INP1   <= p2_lvl;
            INP2   <= {coin1_out | coin2_out, start2, start1};
        end
    end

endmodule
